rgmii_rx_decode: RTL and testbench
==================================

Name: rgmii_rx_decode

Overview:
Consumes the registered rising/falling-edge samples produced by the source-synchronous DDR input stage for RGMII RX (4 data bits plus RX_CTL), and produces a GMII-style byte stream with a per-byte valid strobe. In 1000 Mb/s mode each clock carries one byte. In 10/100 mode, successive rising-edge nibbles are paired into bytes. It also decodes and filters the RGMII in-band link status sent during inter-frame gaps. It runs in the recovered RX clock domain; the next stage is the MAC RX path.

Parameters:
STATUS_FILTER, 4, consecutive identical in-band status samples required before link_* outputs update (range 1..255)

Ports:
clk  input  1  recovered RX clock, same clock as the DDR input stage output clock
rst_n  input  1  asynchronous active-low reset
speed  input  2  configured speed: 2'b00 = 10M, 2'b01 = 100M, 2'b10 = 1000M, 2'b11 is treated as 1000M
in_rxd_q1  input  4  rising-edge data sample
in_rxd_q2  input  4  falling-edge data sample
in_ctl_q1  input  1  rising-edge RX_CTL sample (RX_DV)
in_ctl_q2  input  1  falling-edge RX_CTL sample (RX_DV xor RX_ER)
out_rxd  output  8  assembled byte
out_rx_dv  output  1  byte belongs to a frame
out_rx_er  output  1  receive error on this byte
out_valid  output  1  out_rxd/out_rx_dv/out_rx_er are meaningful this cycle
odd_nibble  output  1  one-cycle pulse: frame ended on an unpaired nibble (10/100 only)
link_up  output  1  filtered in-band link status
link_speed  output  2  filtered in-band speed (same encoding as speed)
link_duplex  output  1  filtered in-band duplex, 1 = full

Behaviour:
- Reset: all outputs 0, state IDLE, filter counter 0, active speed 1000M.
- Stage 0 registers the inputs. Derived signals: dv = ctl_q1, er = ctl_q1 ^ ctl_q2.
- The active speed latches from speed only while dv is 0 in stage 0. A speed change during a frame takes effect after the frame ends.
- 1000M mode: out_rxd = {q2,q1}, with out_rx_dv = dv and out_rx_er = er. out_valid is 1 every cycle. Latency is 2 clk from the input sample to the output.
- 10/100 mode: only q1 and ctl_q1 are used, and er = ctl_q1 ^ ctl_q2 still applies. The state machine has three states:
  - IDLE: stays here while dv = 0. While dv = 0, out_valid pulses every other cycle with out_rx_dv = 0, and out_rx_er = er of the later nibble. On dv = 1, store the nibble as the low half and go to HIGH.
  - HIGH: on dv = 1, emit {q1, low}, set out_rx_er = OR of both nibbles' er, assert out_valid, and go to LOW. On dv = 0, emit {4'h0, low} with out_rx_dv = 1 and out_rx_er = 1, pulse odd_nibble, and go to IDLE.
  - LOW: on dv = 1, store the low nibble and go to HIGH. On dv = 0, go to IDLE with no output.
- Byte latency in 10/100 mode is 2 clk after the high nibble is sampled. out_valid is never high on two consecutive cycles.
- Carrier extension and false carrier (dv = 0, er = 1) pass through with out_rx_dv = 0, out_rx_er = 1, and out_rxd = the raw data.
- In-band status:
  - A sample is taken on every cycle where dv = 0, er = 0, and the active speed is 1000M or the state is IDLE. The sample is rxd_q1[0] = link, rxd_q1[2:1] = speed, rxd_q1[3] = duplex.
  - The counter increments while the sample equals the previous sample, saturating at STATUS_FILTER. It resets to 1 on a mismatch.
  - link_* update when the counter reaches STATUS_FILTER. Cycles with dv or er asserted hold both the counter and the last sample.
- Reset mid-frame: outputs clear immediately (asynchronous assert). After deassertion, nothing is emitted until dv is observed low at least once, so there is no partial frame.

Decomposition:
- rgmii_pkg holds:
  - speed encodings SPEED_10/100/1000;
  - in-band field positions (IB_LINK_BIT, IB_SPEED_LSB, IB_DUPLEX_BIT);
  - the nibble-assembly state enum (IDLE/HIGH/LOW).
- One sub-module, rgmii_inband_status_filter: sample-compare, saturating counter, and link_* registers, parameterised by STATUS_FILTER.

Test Plan:
- 1000M: drive q1/q2 = {5,5}…{D,5}, then frame bytes 0x12, 0x34, with ctl_q1 = ctl_q2 = 1 → out_rxd 0x55…0xD5, 0x12, 0x34, out_rx_dv = 1, out_rx_er = 0, out_valid every cycle, 2-clk latency.
- 100M: nibbles 2,1,4,3 with dv = 1, then dv = 0 → bytes 0x12, 0x34 on alternate cycles, out_valid never back-to-back, odd_nibble = 0.
- 100M odd frame: 3 nibbles 5,5,D, then dv = 0 → byte 0x55, then 0x0D with out_rx_er = 1, odd_nibble pulses once.
- Error: 1000M frame where byte 3 has ctl_q2 = 0 → only byte 3 has out_rx_er = 1.
- In-band status with STATUS_FILTER = 4: 3 idle cycles with rxd = 4'b1101, then 1 cycle of 4'b0000, then 4 cycles of 4'b1101 → link_up = 1, link_speed = 2'b10, link_duplex = 1, updating only after the 4th matching cycle.
- Speed switch to 10M mid-frame, then rst_n pulse mid-frame → the current frame completes in 1000M. After reset all outputs are 0 and no bytes are emitted until dv has gone low.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared encodings for the RGMII receive decoder: speeds, in-band status
// field positions and the 10/100 nibble-assembly states.
package rgmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  localparam int IB_LINK_BIT   = 0;
  localparam int IB_SPEED_LSB  = 1;
  localparam int IB_DUPLEX_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } nib_state_e;

endpackage

// File: rtl/rgmii_inband_status_filter.sv
// Debounces the in-band link status nibble: link_* only follow a sample once it
// has been seen STATUS_FILTER times in a row.
module rgmii_inband_status_filter
  import rgmii_pkg::*;
#(
  parameter int STATUS_FILTER = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sample_en,
  input  logic [3:0] i_sample,
  output logic       o_link_up,
  output logic [1:0] o_link_speed,
  output logic       o_link_duplex
);

  localparam logic [7:0] FMAX = 8'(STATUS_FILTER);

  logic [3:0] r_last;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_match;

  assign w_match = (i_sample == r_last);

  always_comb begin
    w_cnt_nxt = 8'd1;
    if (w_match) w_cnt_nxt = (r_cnt == FMAX) ? FMAX : r_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last        <= '0;
      r_cnt         <= '0;
      o_link_up     <= 1'b0;
      o_link_speed  <= '0;
      o_link_duplex <= 1'b0;
    end else if (i_sample_en) begin
      r_last <= i_sample;
      r_cnt  <= w_cnt_nxt;
      if (w_cnt_nxt == FMAX) begin
        o_link_up     <= i_sample[IB_LINK_BIT];
        o_link_speed  <= i_sample[IB_SPEED_LSB +: 2];
        o_link_duplex <= i_sample[IB_DUPLEX_BIT];
      end
    end
  end

endmodule

// File: rtl/rgmii_rx_decode.sv
// RGMII RX decode: turns registered DDR samples into a GMII byte stream
// (1000M direct, 10/100 nibble pairing) and filters in-band link status.
module rgmii_rx_decode
  import rgmii_pkg::*;
#(
  parameter int STATUS_FILTER = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic [3:0] in_rxd_q1,
  input  logic [3:0] in_rxd_q2,
  input  logic       in_ctl_q1,
  input  logic       in_ctl_q2,
  output logic [7:0] out_rxd,
  output logic       out_rx_dv,
  output logic       out_rx_er,
  output logic       out_valid,
  output logic       odd_nibble,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_duplex
);

  logic [3:0] r_q1, r_q2;
  logic       r_c1, r_c2;
  logic       r_s0_vld;
  logic       r_armed;
  logic [1:0] r_spd;
  nib_state_e r_state;
  logic       r_ph;
  logic [3:0] r_low;
  logic       r_er_low;

  logic       w_dv, w_er, w_gig, w_idle_seen, w_arm, w_ib_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1     <= '0;
      r_q2     <= '0;
      r_c1     <= 1'b0;
      r_c2     <= 1'b0;
      r_s0_vld <= 1'b0;
    end else begin
      r_q1     <= in_rxd_q1;
      r_q2     <= in_rxd_q2;
      r_c1     <= in_ctl_q1;
      r_c2     <= in_ctl_q2;
      r_s0_vld <= 1'b1;
    end
  end

  assign w_dv        = r_c1;
  assign w_er        = r_c1 ^ r_c2;
  // 2'b11 decodes as 1000M along with 2'b10
  assign w_gig       = r_spd[1];
  // r_s0_vld keeps the reset-cleared stage 0 from counting as a real idle sample
  assign w_idle_seen = r_s0_vld & ~w_dv;
  assign w_arm       = r_armed | w_idle_seen;
  assign w_ib_en     = w_idle_seen & ~w_er & (w_gig | (r_state == ST_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_spd   <= SPEED_1000;
    end else if (w_idle_seen) begin
      r_armed <= 1'b1;
      r_spd   <= speed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ph       <= 1'b0;
      r_low      <= '0;
      r_er_low   <= 1'b0;
      out_rxd    <= '0;
      out_rx_dv  <= 1'b0;
      out_rx_er  <= 1'b0;
      out_valid  <= 1'b0;
      odd_nibble <= 1'b0;
    end else begin
      out_rxd    <= '0;
      out_rx_dv  <= 1'b0;
      out_rx_er  <= 1'b0;
      out_valid  <= 1'b0;
      odd_nibble <= 1'b0;
      if (!w_arm) begin
        r_state <= ST_IDLE;
        r_ph    <= 1'b0;
      end else if (w_gig) begin
        r_state   <= ST_IDLE;
        r_ph      <= 1'b0;
        out_rxd   <= {r_q2, r_q1};
        out_rx_dv <= w_dv;
        out_rx_er <= w_er;
        out_valid <= 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_dv) begin
              r_low    <= r_q1;
              r_er_low <= w_er;
              r_ph     <= 1'b0;
              r_state  <= ST_HIGH;
            end else begin
              // idle/false-carrier nibbles still pair up so raw data passes through
              r_ph <= ~r_ph;
              if (!r_ph) begin
                r_low <= r_q1;
              end else begin
                out_rxd   <= {r_q1, r_low};
                out_rx_er <= w_er;
                out_valid <= 1'b1;
              end
            end
          end
          ST_HIGH: begin
            out_valid <= 1'b1;
            out_rx_dv <= 1'b1;
            if (w_dv) begin
              out_rxd   <= {r_q1, r_low};
              out_rx_er <= r_er_low | w_er;
              r_state   <= ST_LOW;
            end else begin
              out_rxd    <= {4'h0, r_low};
              out_rx_er  <= 1'b1;
              odd_nibble <= 1'b1;
              r_ph       <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
          ST_LOW: begin
            if (w_dv) begin
              r_low    <= r_q1;
              r_er_low <= w_er;
              r_state  <= ST_HIGH;
            end else begin
              r_ph    <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_ph    <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  rgmii_inband_status_filter #(
    .STATUS_FILTER (STATUS_FILTER)
  ) u_ib_filt (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sample_en   (w_ib_en),
    .i_sample      (r_q1),
    .o_link_up     (link_up),
    .o_link_speed  (link_speed),
    .o_link_duplex (link_duplex)
  );

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed bench for rgmii_rx_decode: after each drive call the outputs show
// the result of the vector driven by the previous call (2-clk latency).
module tb_rgmii_rx_decode;
  import rgmii_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] speed;
  logic [3:0] in_rxd_q1, in_rxd_q2;
  logic       in_ctl_q1, in_ctl_q2;
  logic [7:0] out_rxd;
  logic       out_rx_dv, out_rx_er, out_valid, odd_nibble;
  logic       link_up, link_duplex;
  logic [1:0] link_speed;

  int n_chk = 0;
  int n_err = 0;

  rgmii_rx_decode #(.STATUS_FILTER(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .speed       (speed),
    .in_rxd_q1   (in_rxd_q1),
    .in_rxd_q2   (in_rxd_q2),
    .in_ctl_q1   (in_ctl_q1),
    .in_ctl_q2   (in_ctl_q2),
    .out_rxd     (out_rxd),
    .out_rx_dv   (out_rx_dv),
    .out_rx_er   (out_rx_er),
    .out_valid   (out_valid),
    .odd_nibble  (odd_nibble),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic co(input string tag, input logic v, input logic dv, input logic er,
                    input logic [7:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".dv"},    32'(out_rx_dv), 32'(dv));
    chk({tag, ".er"},    32'(out_rx_er), 32'(er));
    chk({tag, ".rxd"},   32'(out_rxd),   32'(d));
  endtask

  task automatic drv(input logic [3:0] q1, input logic [3:0] q2, input logic c1, input logic c2);
    in_rxd_q1 = q1;
    in_rxd_q2 = q2;
    in_ctl_q1 = c1;
    in_ctl_q2 = c2;
    @(posedge clk);
    #1;
  endtask

  task automatic gb(input logic [7:0] b, input logic c1, input logic c2);
    drv(b[3:0], b[7:4], c1, c2);
  endtask

  task automatic nib(input logic [3:0] q, input logic dv);
    drv(q, 4'h0, dv, dv);
  endtask

  logic v0, v1;

  initial begin
    rst_n = 1'b0;
    speed = SPEED_1000;
    in_rxd_q1 = '0; in_rxd_q2 = '0; in_ctl_q1 = 1'b0; in_ctl_q2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    co("rst", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst.odd", 32'(odd_nibble), 32'd0);
    chk("rst.link", 32'({link_up, link_speed, link_duplex}), 32'd0);
    rst_n = 1'b1;

    // 1000M frame: preamble, SFD, 0x12, 0x34
    repeat (3) gb(8'h00, 1'b0, 1'b0);
    gb(8'h55, 1'b1, 1'b1);
    co("g.lat", 1'b1, 1'b0, 1'b0, 8'h00);
    gb(8'h55, 1'b1, 1'b1); co("g.p0", 1'b1, 1'b1, 1'b0, 8'h55);
    gb(8'hD5, 1'b1, 1'b1); co("g.p1", 1'b1, 1'b1, 1'b0, 8'h55);
    gb(8'h12, 1'b1, 1'b1); co("g.sfd", 1'b1, 1'b1, 1'b0, 8'hD5);
    gb(8'h34, 1'b1, 1'b1); co("g.b12", 1'b1, 1'b1, 1'b0, 8'h12);
    gb(8'h00, 1'b0, 1'b0); co("g.b34", 1'b1, 1'b1, 1'b0, 8'h34);
    gb(8'h00, 1'b0, 1'b0); co("g.idle", 1'b1, 1'b0, 1'b0, 8'h00);

    // 1000M error on byte 3 only
    gb(8'h55, 1'b1, 1'b1);
    gb(8'h55, 1'b1, 1'b1); co("e.b1", 1'b1, 1'b1, 1'b0, 8'h55);
    gb(8'hD5, 1'b1, 1'b0); co("e.b2", 1'b1, 1'b1, 1'b0, 8'h55);
    gb(8'h12, 1'b1, 1'b1); co("e.b3", 1'b1, 1'b1, 1'b1, 8'hD5);
    gb(8'h00, 1'b0, 1'b0); co("e.b4", 1'b1, 1'b1, 1'b0, 8'h12);

    // carrier extension / false carrier passes raw data
    gb(8'hAF, 1'b0, 1'b1);
    gb(8'h00, 1'b0, 1'b0); co("cx", 1'b1, 1'b0, 1'b1, 8'hAF);

    // 100M: idle pulses alternate, then nibbles 2,1,4,3
    speed = SPEED_100;
    repeat (4) nib(4'h0, 1'b0);
    nib(4'h0, 1'b0); v0 = out_valid;
    nib(4'h0, 1'b0); v1 = out_valid;
    chk("m.idle_alt", 32'(v0) + 32'(v1), 32'd1);
    nib(4'h2, 1'b1);
    nib(4'h1, 1'b1); chk("m.lo.valid", 32'(out_valid), 32'd0);
    nib(4'h4, 1'b1); co("m.b12", 1'b1, 1'b1, 1'b0, 8'h12);
    nib(4'h3, 1'b1); chk("m.gap.valid", 32'(out_valid), 32'd0);
    nib(4'h0, 1'b0); co("m.b34", 1'b1, 1'b1, 1'b0, 8'h34);
    chk("m.odd0", 32'(odd_nibble), 32'd0);
    nib(4'h0, 1'b0); chk("m.end.valid", 32'(out_valid), 32'd0);
    chk("m.end.odd", 32'(odd_nibble), 32'd0);
    nib(4'h0, 1'b0); chk("m.i0.valid", 32'(out_valid), 32'd0);
    nib(4'h0, 1'b0); co("m.i1", 1'b1, 1'b0, 1'b0, 8'h00);

    // 100M odd frame: 5,5,D
    nib(4'h5, 1'b1);
    nib(4'h5, 1'b1);
    nib(4'hD, 1'b1); co("o.b55", 1'b1, 1'b1, 1'b0, 8'h55);
    nib(4'h0, 1'b0); chk("o.gap.valid", 32'(out_valid), 32'd0);
    nib(4'h0, 1'b0); co("o.b0d", 1'b1, 1'b1, 1'b1, 8'h0D);
    chk("o.odd1", 32'(odd_nibble), 32'd1);
    nib(4'h0, 1'b0); chk("o.after.valid", 32'(out_valid), 32'd0);
    chk("o.after.odd", 32'(odd_nibble), 32'd0);
    nib(4'h0, 1'b0); co("o.idle", 1'b1, 1'b0, 1'b0, 8'h00);

    // in-band status in 1000M: 3x1101, 1x0000, 4x1101
    speed = SPEED_1000;
    repeat (6) gb(8'h00, 1'b0, 1'b0);
    chk("ib.init", 32'(link_up), 32'd0);
    repeat (3) gb(8'h0D, 1'b0, 1'b0);
    gb(8'h00, 1'b0, 1'b0); chk("ib.3match", 32'(link_up), 32'd0);
    repeat (4) gb(8'h0D, 1'b0, 1'b0);
    chk("ib.pre4", 32'(link_up), 32'd0);
    gb(8'h00, 1'b0, 1'b0);
    chk("ib.up", 32'(link_up), 32'd1);
    chk("ib.speed", 32'(link_speed), 32'(2'b10));
    chk("ib.duplex", 32'(link_duplex), 32'd1);

    // speed change to 10M mid-frame keeps 1000M until the frame ends
    gb(8'h55, 1'b1, 1'b1);
    gb(8'h55, 1'b1, 1'b1);
    speed = SPEED_10;
    gb(8'h12, 1'b1, 1'b1);
    gb(8'h34, 1'b1, 1'b1); co("sw.b12", 1'b1, 1'b1, 1'b0, 8'h12);
    gb(8'h56, 1'b1, 1'b1); co("sw.b34", 1'b1, 1'b1, 1'b0, 8'h34);

    // reset mid-frame: immediate clear, nothing until dv goes low
    rst_n = 1'b0;
    #1;
    co("mr.async", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("mr.link", 32'(link_up), 32'd0);
    gb(8'h78, 1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gb(8'h9A, 1'b1, 1'b1);
      co("mr.hold", 1'b0, 1'b0, 1'b0, 8'h00);
    end
    repeat (4) nib(4'h0, 1'b0);
    nib(4'h6, 1'b1);
    nib(4'h7, 1'b1); chk("mr.10m.lo", 32'(out_valid), 32'd0);
    nib(4'h0, 1'b0); co("mr.10m.b76", 1'b1, 1'b1, 1'b0, 8'h76);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
